// File: rtl/pio_mem_rd_arb.sv
// pio_mem_rd_arb: round-robin arbiter for the application read port of a
// PIO-accessible BRAM. Clients are granted in rotating order and never more than
// once while a read is in flight. Read data is broadcast, and a one-hot req_ack
// tells each client when the data is its own. While a PIO read is pending, a
// starvation guard limits the number of back-to-back app reads to MAX_BURST. It
// then leaves one idle slot so that the PIO read can reach the RAM.
//
// Optional build macro: PIO_MEM_ARB_STATS_EN
//   When it is defined, gap_cnt counts forced gap cycles and saturates at 16'hFFFF.
//   When it is not defined, gap_cnt is tied to zero.
module pio_mem_rd_arb #(
  parameter int NREQ        = 4,
  parameter int DEPTH_NBITS = 10,
  parameter int WIDTH       = 20,
  parameter int MAX_BURST   = 8
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NREQ-1:0]             req_rd,
  input  logic [NREQ*DEPTH_NBITS-1:0] req_raddr,
  output logic [NREQ-1:0]             req_ack,
  output logic [WIDTH-1:0]            req_rdata,
  input  logic                        pio_rd_pend,
  output logic                        app_mem_rd,
  output logic [DEPTH_NBITS-1:0]      app_mem_raddr,
  input  logic                        app_mem_ack,
  input  logic [WIDTH-1:0]            app_mem_rdata,
  output logic [15:0]                 gap_cnt
);

  localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int BW = $clog2(MAX_BURST + 1);

  typedef enum logic [0:0] {
    ST_ISSUE = 1'b0,
    ST_GAP   = 1'b1
  } state_t;

  state_t                  state_r;
  state_t                  state_s;
  logic [BW-1:0]           burst_cnt_r;
  logic [BW-1:0]           burst_nxt_s;
  logic                    gap_slot_s;

  logic [IW-1:0]           rr_ptr_r;
  logic [NREQ-1:0]         outstanding_r;
  logic [NREQ-1:0]         outstanding_nxt_s;
  logic [IW-1:0]           tag1_r;
  logic                    tag1_vld_r;
  logic [IW-1:0]           tag2_r;
  logic                    tag2_vld_r;

  logic [NREQ-1:0]         eligible_s;
  logic [2*NREQ-1:0]       elig_dbl_s;
  logic [NREQ-1:0]         elig_rot_s;
  logic                    found_s;
  logic                    grant_s;
  logic [IW-1:0]           winner_s;
  logic [DEPTH_NBITS-1:0]  sel_addr_s;
  logic                    ack_fire_s;

  // A client that has a read in flight cannot compete again until its ack has retired.
  assign eligible_s = req_rd & ~outstanding_r;

  // Rotate the eligibility vector so that bit 0 is the client at rr_ptr.
  assign elig_dbl_s = {eligible_s, eligible_s} >> rr_ptr_r;
  assign elig_rot_s = elig_dbl_s[NREQ-1:0];
  assign found_s    = |elig_rot_s;

  // Priority pick: the lowest set bit of the rotated vector, mapped back to a client index.
  always_comb begin
    winner_s = {IW{1'b0}};
    for (int k = NREQ - 1; k >= 0; k--) begin
      int idx;
      idx = int'(rr_ptr_r) + k;
      idx = (idx >= NREQ) ? (idx - NREQ) : idx;
      winner_s = elig_rot_s[k] ? IW'(idx) : winner_s;
    end
  end

  // Select the address of the winning client.
  always_comb begin
    sel_addr_s = {DEPTH_NBITS{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      sel_addr_s = (winner_s == IW'(i)) ? req_raddr[i*DEPTH_NBITS +: DEPTH_NBITS] : sel_addr_s;
    end
  end

  // Starvation guard. The slot whose read would exceed MAX_BURST back-to-back reads
  // with a PIO read pending is the gap slot, and no grant is made in it. The
  // following cycle (ST_GAP) sees app_mem_rd=0 on the RAM port.
  always_comb begin
    state_s     = state_r;
    burst_nxt_s = burst_cnt_r;
    gap_slot_s  = 1'b0;
    case (state_r)
      ST_ISSUE: begin
        if (app_mem_rd && pio_rd_pend) begin
          if (burst_cnt_r == BW'(MAX_BURST - 1)) begin
            gap_slot_s  = 1'b1;
            state_s     = ST_GAP;
            burst_nxt_s = {BW{1'b0}};
          end else begin
            burst_nxt_s = burst_cnt_r + BW'(1);
          end
        end else begin
          burst_nxt_s = {BW{1'b0}};
        end
      end
      ST_GAP: begin
        state_s     = ST_ISSUE;
        burst_nxt_s = {BW{1'b0}};
      end
      default: begin
        state_s     = ST_ISSUE;
        burst_nxt_s = {BW{1'b0}};
      end
    endcase
  end

  assign grant_s    = found_s & ~gap_slot_s;
  assign ack_fire_s = app_mem_ack & tag2_vld_r;

  // On a grant, set the winner's outstanding bit. On an ack, clear the bit of the
  // client that was acked. These can never be the same client.
  always_comb begin
    outstanding_nxt_s = outstanding_r;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_s && (winner_s == IW'(i))) begin
        outstanding_nxt_s[i] = 1'b1;
      end else if (ack_fire_s && (tag2_r == IW'(i))) begin
        outstanding_nxt_s[i] = 1'b0;
      end else begin
        outstanding_nxt_s[i] = outstanding_r[i];
      end
    end
  end

  // Decode the ack to a one-hot value. An ack with no valid tag behind it is ignored.
  always_comb begin
    req_ack = {NREQ{1'b0}};
    for (int i = 0; i < NREQ; i++) begin
      req_ack[i] = ack_fire_s & (tag2_r == IW'(i));
    end
  end

  assign req_rdata = app_mem_rdata;

  // Guard FSM state and the counter of back-to-back reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_ISSUE;
      burst_cnt_r <= {BW{1'b0}};
    end else begin
      state_r     <= state_s;
      burst_cnt_r <= burst_nxt_s;
    end
  end

  // Issue stage: the registered RAM strobe and address, the rotating pointer and the tag pipe.
  always_ff @(posedge clk) begin
    if (rst) begin
      app_mem_rd    <= 1'b0;
      app_mem_raddr <= {DEPTH_NBITS{1'b0}};
      rr_ptr_r      <= {IW{1'b0}};
      outstanding_r <= {NREQ{1'b0}};
      tag1_r        <= {IW{1'b0}};
      tag1_vld_r    <= 1'b0;
      tag2_r        <= {IW{1'b0}};
      tag2_vld_r    <= 1'b0;
    end else begin
      app_mem_rd    <= grant_s;
      outstanding_r <= outstanding_nxt_s;
      tag1_r        <= winner_s;
      tag1_vld_r    <= grant_s;
      tag2_r        <= tag1_r;
      tag2_vld_r    <= tag1_vld_r;
      if (grant_s) begin
        app_mem_raddr <= sel_addr_s;
        rr_ptr_r      <= (winner_s == IW'(NREQ - 1)) ? {IW{1'b0}} : (winner_s + IW'(1));
      end
    end
  end

`ifdef PIO_MEM_ARB_STATS_EN
  logic [15:0] gap_cnt_r;

  // Count cycles spent in the gap state. The counter saturates rather than wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      gap_cnt_r <= 16'h0000;
    end else if ((state_r == ST_GAP) && (gap_cnt_r != 16'hFFFF)) begin
      gap_cnt_r <= gap_cnt_r + 16'h0001;
    end
  end

  assign gap_cnt = gap_cnt_r;
`else
  assign gap_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_pio_mem_rd_arb.sv
// Testbench for pio_mem_rd_arb. It contains a behavioural RAM and client drivers.
// The reference model keeps cycle-indexed expectations: a grant at cycle c gives
// a read at c+1 and an ack at c+2, and the client may compete again from c+3.
module tb_pio_mem_rd_arb;
  localparam int N  = 4;
  localparam int D  = 10;
  localparam int W  = 20;
  localparam int MB = 8;

  logic           clk = 1'b0;
  logic           rst;
  logic [N-1:0]   req_rd;
  logic [N*D-1:0] req_raddr;
  logic [N-1:0]   req_ack;
  logic [W-1:0]   req_rdata;
  logic           pio_rd_pend;
  logic           app_mem_rd;
  logic [D-1:0]   app_mem_raddr;
  logic           app_mem_ack;
  logic [W-1:0]   app_mem_rdata;
  logic [15:0]    gap_cnt;
  logic           inject;

  pio_mem_rd_arb #(.NREQ(N), .DEPTH_NBITS(D), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .rst(rst), .req_rd(req_rd), .req_raddr(req_raddr), .req_ack(req_ack),
    .req_rdata(req_rdata), .pio_rd_pend(pio_rd_pend), .app_mem_rd(app_mem_rd),
    .app_mem_raddr(app_mem_raddr), .app_mem_ack(app_mem_ack), .app_mem_rdata(app_mem_rdata),
    .gap_cnt(gap_cnt)
  );

  always #5 clk = ~clk;

  // Behavioural RAM: it acks one cycle after each strobe. The bench can also inject a spurious ack.
  logic [W-1:0] mem [0:1023];
  logic         ack_q;
  logic [W-1:0] rdata_q;
  always @(posedge clk) begin
    ack_q   <= app_mem_rd;
    rdata_q <= mem[app_mem_raddr];
  end
  assign app_mem_ack   = ack_q | inject;
  assign app_mem_rdata = rdata_q;

  int chk_cnt = 0;
  int pass_cnt = 0;

  // Stimulus state
  int           mode = 0;          // 0 directed, 1 all clients continuous, 2 random
  logic         rst_v = 1'b1, pend_v = 1'b0, inject_v = 1'b0;
  logic         cl_req [N];
  logic [D-1:0] cl_addr [N];
  logic [N-1:0] acked_last = '0;

  // Reference model state
  int           mcyc = 0;
  int           busy_until [N];
  int           mptr = 0;
  int           run = 0;
  int           m_gaps = 0;
  logic [D-1:0] cur_addr = '0;
  bit           exp_rd_a [int];
  logic [D-1:0] exp_addr_a [int];
  int           exp_ack_a [int];
  logic [W-1:0] exp_data_a [int];
  logic         e_rd;
  logic [D-1:0] e_addr;
  logic [N-1:0] e_ack;
  logic [W-1:0] e_data;

  // Advance one cycle. Drive inputs just after the edge, then at the falling edge
  // work out what the model expects for this cycle and update the model.
  task automatic step();
    bit found;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) begin
      if (mode != 0 && (!cl_req[i] || acked_last[i] === 1'b1)) begin
        cl_req[i]  = (mode == 1) ? 1'b1 : 1'($urandom_range(0, 1));
        cl_addr[i] = D'($urandom_range(0, 1023));
      end
      req_rd[i] = cl_req[i];
      req_raddr[i*D +: D] = cl_addr[i];
    end
    rst = rst_v; pio_rd_pend = pend_v; inject = inject_v;
    @(negedge clk);
    e_rd = exp_rd_a.exists(mcyc);
    if (e_rd) cur_addr = exp_addr_a[mcyc];
    e_addr = cur_addr;
    if (exp_ack_a.exists(mcyc)) begin
      e_ack = 4'b0001 << exp_ack_a[mcyc];
      e_data = exp_data_a[mcyc];
    end else begin
      e_ack = '0; e_data = '0;
    end
    acked_last = req_ack;
    if (rst_v) begin
      exp_rd_a.delete(); exp_addr_a.delete(); exp_ack_a.delete(); exp_data_a.delete();
      for (int i = 0; i < N; i++) busy_until[i] = 0;
      mptr = 0; run = 0; m_gaps = 0; cur_addr = '0;
    end else begin
      run = (e_rd && pend_v) ? run + 1 : 0;
      if (run == MB) begin
        run = 0;
        m_gaps++;
      end else begin
        found = 0;
        for (int k = 0; k < N; k++) begin
          int idx;
          idx = (mptr + k) % N;
          if (!found && cl_req[idx] && mcyc >= busy_until[idx]) begin
            found = 1;
            exp_rd_a[mcyc+1]   = 1'b1;
            exp_addr_a[mcyc+1] = cl_addr[idx];
            exp_ack_a[mcyc+2]  = idx;
            exp_data_a[mcyc+2] = mem[cl_addr[idx]];
            busy_until[idx]    = mcyc + 3;
            mptr = (idx + 1) % N;
          end
        end
      end
    end
    mcyc++;
  endtask

  task automatic test_reset();
    rst_v = 1'b1;
    repeat (3) step();
    rst_v = 1'b0;
    step();
    chk_cnt++; if (app_mem_rd !== 1'b0) $display("FAIL reset_rd got=%b want=0", app_mem_rd); else pass_cnt++;
    chk_cnt++; if (app_mem_raddr !== 10'h000) $display("FAIL reset_raddr got=%h want=000", app_mem_raddr); else pass_cnt++;
    chk_cnt++; if (req_ack !== 4'b0000) $display("FAIL reset_ack got=%b want=0000", req_ack); else pass_cnt++;
    chk_cnt++; if (gap_cnt !== 16'h0000) $display("FAIL reset_gap_cnt got=%h want=0000", gap_cnt); else pass_cnt++;
  endtask

  task automatic test_single();
    cl_req[2] = 1'b1; cl_addr[2] = 10'h05A;
    step();
    step();
    chk_cnt++; if (app_mem_rd !== 1'b1 || app_mem_raddr !== 10'h05A)
      $display("FAIL single_issue got rd=%b addr=%h want rd=1 addr=05a", app_mem_rd, app_mem_raddr); else pass_cnt++;
    step();
    chk_cnt++; if (req_ack !== 4'b0100) $display("FAIL single_ack got=%b want=0100", req_ack); else pass_cnt++;
    chk_cnt++; if (req_rdata !== 20'h12345) $display("FAIL single_data got=%h want=12345", req_rdata); else pass_cnt++;
    cl_req[2] = 1'b0;
    step();
    chk_cnt++; if (app_mem_rd !== 1'b0) $display("FAIL single_no_reissue got rd=%b want 0", app_mem_rd); else pass_cnt++;
  endtask

  task automatic test_spurious_ack();
    repeat (2) step();
    inject_v = 1'b1;
    step();
    chk_cnt++; if (req_ack !== 4'b0000) $display("FAIL spurious_ack got=%b want=0000", req_ack); else pass_cnt++;
    inject_v = 1'b0;
    step();
    chk_cnt++; if (req_ack !== 4'b0000) $display("FAIL spurious_after got=%b want=0000", req_ack); else pass_cnt++;
  endtask

  task automatic test_reset_mid();
    cl_req[1] = 1'b1; cl_addr[1] = 10'h2A7;
    step();
    rst_v = 1'b1;
    step();
    chk_cnt++; if (app_mem_rd !== 1'b1 || app_mem_raddr !== 10'h2A7)
      $display("FAIL rstmid_issue got rd=%b addr=%h want rd=1 addr=2a7", app_mem_rd, app_mem_raddr); else pass_cnt++;
    rst_v = 1'b0;
    step();
    chk_cnt++; if (req_ack !== 4'b0000 || app_mem_rd !== 1'b0 || app_mem_raddr !== 10'h000)
      $display("FAIL rstmid_dropped got ack=%b rd=%b addr=%h want 0000/0/000", req_ack, app_mem_rd, app_mem_raddr); else pass_cnt++;
    step();
    chk_cnt++; if (app_mem_rd !== 1'b1 || app_mem_raddr !== 10'h2A7)
      $display("FAIL rstmid_reissue got rd=%b addr=%h want rd=1 addr=2a7", app_mem_rd, app_mem_raddr); else pass_cnt++;
    step();
    chk_cnt++; if (req_ack !== 4'b0010 || req_rdata !== mem[10'h2A7])
      $display("FAIL rstmid_ack got ack=%b data=%h want 0010/%h", req_ack, req_rdata, mem[10'h2A7]); else pass_cnt++;
    cl_req[1] = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    int order [$];
    rst_v = 1'b1; step(); rst_v = 1'b0;
    mode = 1; pend_v = 1'b0;
    for (int c = 0; c < 20; c++) begin
      step();
      chk_cnt++;
      if (app_mem_rd !== e_rd || app_mem_raddr !== e_addr)
        $display("FAIL rr_issue cyc=%0d got rd=%b addr=%h want rd=%b addr=%h", c, app_mem_rd, app_mem_raddr, e_rd, e_addr);
      else pass_cnt++;
      chk_cnt++;
      if (req_ack !== e_ack || (e_ack != '0 && req_rdata !== e_data))
        $display("FAIL rr_ack cyc=%0d got ack=%b data=%h want ack=%b data=%h", c, req_ack, req_rdata, e_ack, e_data);
      else pass_cnt++;
      for (int j = 0; j < N; j++) if (req_ack[j] === 1'b1) order.push_back(j);
    end
    for (int n = 0; n < 8; n++) begin
      chk_cnt++;
      if (order.size() <= n) $display("FAIL rr_order n=%0d got no ack want client %0d", n, n % N);
      else if (order[n] != n % N) $display("FAIL rr_order n=%0d got client %0d want %0d", n, order[n], n % N);
      else pass_cnt++;
    end
  endtask

  task automatic test_burst_gap();
    int run_o = 0, max_run = 0, zeros = 0;
    pend_v = 1'b1;
    for (int c = 0; c < 45; c++) begin
      step();
      chk_cnt++;
      if (app_mem_rd !== e_rd || app_mem_raddr !== e_addr)
        $display("FAIL burst_issue cyc=%0d got rd=%b addr=%h want rd=%b addr=%h", c, app_mem_rd, app_mem_raddr, e_rd, e_addr);
      else pass_cnt++;
      chk_cnt++;
      if (req_ack !== e_ack || (e_ack != '0 && req_rdata !== e_data))
        $display("FAIL burst_ack cyc=%0d got ack=%b data=%h want ack=%b data=%h", c, req_ack, req_rdata, e_ack, e_data);
      else pass_cnt++;
      if (app_mem_rd === 1'b1) begin
        run_o++;
        if (run_o > max_run) max_run = run_o;
      end else begin
        run_o = 0;
        zeros++;
      end
    end
    chk_cnt++; if (max_run != MB) $display("FAIL burst_len got=%0d want=%0d", max_run, MB); else pass_cnt++;
    chk_cnt++; if (zeros != 45 / (MB + 1)) $display("FAIL burst_gaps got=%0d want=%0d", zeros, 45 / (MB + 1)); else pass_cnt++;
    pend_v = 1'b0;
    repeat (3) step();
    chk_cnt++;
`ifdef PIO_MEM_ARB_STATS_EN
    if (gap_cnt !== 16'(m_gaps)) $display("FAIL burst_gap_cnt got=%0d want=%0d", gap_cnt, m_gaps); else pass_cnt++;
`else
    if (gap_cnt !== 16'h0000) $display("FAIL burst_gap_cnt got=%0d want=0", gap_cnt); else pass_cnt++;
`endif
  endtask

  task automatic test_no_pend();
    int zeros = 0;
    rst_v = 1'b1; pend_v = 1'b0; step(); rst_v = 1'b0;
    for (int c = 0; c < 30; c++) begin
      step();
      if (c >= 1 && app_mem_rd !== 1'b1) zeros++;
    end
    chk_cnt++; if (zeros != 0) $display("FAIL nopend_idle got=%0d idle cycles want=0", zeros); else pass_cnt++;
    chk_cnt++; if (gap_cnt !== 16'h0000) $display("FAIL nopend_gap_cnt got=%0d want=0", gap_cnt); else pass_cnt++;
  endtask

  task automatic test_random();
    mode = 2;
    for (int c = 0; c < 400; c++) begin
      pend_v = ($urandom_range(0, 3) != 0);
      rst_v  = ($urandom_range(0, 99) == 0);
      step();
      chk_cnt++;
      if (app_mem_rd !== e_rd || app_mem_raddr !== e_addr)
        $display("FAIL rand_issue cyc=%0d got rd=%b addr=%h want rd=%b addr=%h", c, app_mem_rd, app_mem_raddr, e_rd, e_addr);
      else pass_cnt++;
      chk_cnt++;
      if (req_ack !== e_ack || (e_ack != '0 && req_rdata !== e_data))
        $display("FAIL rand_ack cyc=%0d got ack=%b data=%h want ack=%b data=%h", c, req_ack, req_rdata, e_ack, e_data);
      else pass_cnt++;
    end
    rst_v = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = W'($urandom);
    mem[10'h05A] = 20'h12345;
    for (int i = 0; i < N; i++) begin
      cl_req[i] = 1'b0; cl_addr[i] = '0; busy_until[i] = 0;
    end
    rst = 1'b1; req_rd = '0; req_raddr = '0; pio_rd_pend = 1'b0; inject = 1'b0;
    test_reset();
    test_single();
    test_spurious_ack();
    test_reset_mid();
    test_round_robin();
    test_burst_gap();
    test_no_pend();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule
